// File: rtl/cmult_pkg.sv
// Shared types and arithmetic helpers for the streaming complex multiplier.
// Datapath widths derive from the module parameters through the width helpers below.
package cmult_pkg;

  localparam int CALC_W = 64;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic       conj;
    logic [4:0] shift;
  } stage_ctrl_t;

  typedef struct packed {
    logic signed [CALC_W-1:0] value;
    logic                     sat;
  } rs_result_t;

  function automatic int prod_w(input int in_w, input int ref_w);
    return in_w + ref_w;
  endfunction

  function automatic int sum_w(input int in_w, input int ref_w);
    return in_w + ref_w + 1;
  endfunction

  // Round half up, arithmetic shift right, then clip to an out_w-bit signed range.
  function automatic rs_result_t round_sat(input logic signed [CALC_W-1:0] x,
                                           input logic [4:0] shift,
                                           input int out_w);
    logic signed [CALC_W-1:0] half;
    logic signed [CALC_W-1:0] rounded;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    rs_result_t r;
    half = '0;
    if (shift == 5'd0) begin
      rounded = x;
    end else begin
      half = CALC_W'(1) << (shift - 5'd1);
      rounded = (x + half) >>> shift;
    end
    max_v = (CALC_W'(1) << (out_w - 1)) - CALC_W'(1);
    min_v = ~max_v;
    r.sat = 1'b0;
    r.value = rounded;
    if (rounded > max_v) begin
      r.value = max_v;
      r.sat = 1'b1;
    end else if (rounded < min_v) begin
      r.value = min_v;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Enable-gated product, sum and round/saturate stages of the complex multiplier.
// Every register holds its value while en is low so downstream backpressure freezes the pipe.
import cmult_pkg::*;

module cmult_pipe #(
  parameter int IN_W  = 16,
  parameter int REF_W = 16,
  parameter int OUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  stage_ctrl_t          in_ctrl,
  input  logic [2*IN_W-1:0]    in_a,
  input  logic [2*REF_W-1:0]   in_b,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [2*OUT_W-1:0]   out_data,
  output logic                 sat_evt
);

  localparam int PROD_W = prod_w(IN_W, REF_W);
  localparam int SUM_W  = sum_w(IN_W, REF_W);

  logic signed [IN_W-1:0]  ar, ai;
  logic signed [REF_W-1:0] br, bi;

  assign ar = in_a[IN_W-1:0];
  assign ai = in_a[2*IN_W-1:IN_W];
  assign br = in_b[REF_W-1:0];
  assign bi = in_b[2*REF_W-1:REF_W];

  stage_ctrl_t s3_ctrl_q, s3_ctrl_d;
  stage_ctrl_t s4_ctrl_q, s4_ctrl_d;
  logic signed [PROD_W-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic signed [SUM_W-1:0]  re_q, re_d, im_q, im_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [2*OUT_W-1:0]       out_data_q, out_data_d;
  rs_result_t               rs_re, rs_im;

  always_comb begin
    s3_ctrl_d   = s3_ctrl_q;
    s4_ctrl_d   = s4_ctrl_q;
    rr_d        = rr_q;
    ii_d        = ii_q;
    ri_d        = ri_q;
    ir_d        = ir_q;
    re_d        = re_q;
    im_d        = im_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    rs_re       = round_sat(CALC_W'(re_q), s4_ctrl_q.shift, OUT_W);
    rs_im       = round_sat(CALC_W'(im_q), s4_ctrl_q.shift, OUT_W);
    if (en) begin
      s3_ctrl_d = in_ctrl;
      rr_d      = PROD_W'(ar) * PROD_W'(br);
      ii_d      = PROD_W'(ai) * PROD_W'(bi);
      ri_d      = PROD_W'(ar) * PROD_W'(bi);
      ir_d      = PROD_W'(ai) * PROD_W'(br);
      s4_ctrl_d = s3_ctrl_q;
      // Conjugating the reference flips the sign of every bi term.
      if (s3_ctrl_q.conj) begin
        re_d = SUM_W'(rr_q) + SUM_W'(ii_q);
        im_d = SUM_W'(ir_q) - SUM_W'(ri_q);
      end else begin
        re_d = SUM_W'(rr_q) - SUM_W'(ii_q);
        im_d = SUM_W'(ri_q) + SUM_W'(ir_q);
      end
      out_valid_d = s4_ctrl_q.valid;
      out_last_d  = s4_ctrl_q.last;
      if (s4_ctrl_q.valid) begin
        out_data_d = {rs_im.value[OUT_W-1:0], rs_re.value[OUT_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_ctrl_q   <= '0;
      s4_ctrl_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s3_ctrl_q   <= s3_ctrl_d;
      s4_ctrl_q   <= s4_ctrl_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    rr_q <= rr_d;
    ii_q <= ii_d;
    ri_q <= ri_d;
    ir_q <= ir_d;
    re_q <= re_d;
    im_q <= im_d;
  end

  assign sat_evt   = en && s4_ctrl_q.valid && (rs_re.sat || rs_im.sat);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/cmult_ref_stream.sv
// Streams complex samples against a per-index reference held in external BRAM.
// Handles the AXI handshake, frame pointer, per-frame configuration and sticky flags.
import cmult_pkg::*;

module cmult_ref_stream #(
  parameter int IN_W      = 16,
  parameter int REF_W     = 16,
  parameter int OUT_W     = 16,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 1024
) (
  input  logic                 S_AXIS_ACLK,
  input  logic                 S_AXIS_ARESETN,
  input  logic [2*IN_W-1:0]    S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  input  logic                 S_AXIS_TLAST,
  output logic                 S_AXIS_TREADY,
  output logic [ADDR_W-1:0]    BRAM_ADDR,
  output logic                 BRAM_EN,
  input  logic [2*REF_W-1:0]   BRAM_DATAIN,
  output logic [2*OUT_W-1:0]   M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  output logic                 M_AXIS_TLAST,
  input  logic                 M_AXIS_TREADY,
  input  logic                 CFG_CONJ,
  input  logic [4:0]           CFG_SHIFT,
  input  logic                 CLR_FLAGS,
  output logic                 SAT_FLAG,
  output logic                 TLAST_ERR
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

  logic                 en, accept, at_start, at_end, frame_err, sat_evt;
  logic                 m_valid, m_last;
  logic [2*OUT_W-1:0]   m_data;
  logic                 beat_conj;
  logic [4:0]           beat_shift;

  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                 cfg_conj_q, cfg_conj_d;
  logic [4:0]           cfg_shift_q, cfg_shift_d;
  stage_ctrl_t          s1_ctrl_q, s1_ctrl_d, s2_ctrl_q, s2_ctrl_d;
  logic [2*IN_W-1:0]    s1_data_q, s1_data_d, s2_a_q, s2_a_d;
  logic [2*REF_W-1:0]   s2_b_q, s2_b_d;
  logic                 sat_flag_q, sat_flag_d, tlast_err_q, tlast_err_d;

  assign en        = !m_valid || M_AXIS_TREADY;
  assign accept    = S_AXIS_TVALID && en;
  assign at_start  = (rd_ptr_q == '0);
  assign at_end    = (rd_ptr_q == LAST_PTR);
  assign frame_err = accept && (S_AXIS_TLAST != at_end);
  // The first beat of a frame uses the live config; later beats reuse the latched copy.
  assign beat_conj  = at_start ? CFG_CONJ : cfg_conj_q;
  assign beat_shift = at_start ? CFG_SHIFT : cfg_shift_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    cfg_conj_d  = cfg_conj_q;
    cfg_shift_d = cfg_shift_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_data_d   = s1_data_q;
    s2_ctrl_d   = s2_ctrl_q;
    s2_a_d      = s2_a_q;
    s2_b_d      = s2_b_q;
    sat_flag_d  = sat_flag_q;
    tlast_err_d = tlast_err_q;
    if (accept) begin
      if (at_start) begin
        cfg_conj_d  = CFG_CONJ;
        cfg_shift_d = CFG_SHIFT;
      end
      rd_ptr_d = (at_end || S_AXIS_TLAST) ? '0 : rd_ptr_q + ADDR_W'(1);
    end
    if (en) begin
      s1_ctrl_d.valid = S_AXIS_TVALID;
      s1_ctrl_d.last  = S_AXIS_TLAST;
      s1_ctrl_d.conj  = beat_conj;
      s1_ctrl_d.shift = beat_shift;
      s1_data_d       = S_AXIS_TDATA;
      s2_ctrl_d       = s1_ctrl_q;
      s2_a_d          = s1_data_q;
      s2_b_d          = BRAM_DATAIN;
    end
    if (CLR_FLAGS) begin
      sat_flag_d  = 1'b0;
      tlast_err_d = 1'b0;
    end
    if (sat_evt) sat_flag_d = 1'b1;
    if (frame_err) tlast_err_d = 1'b1;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      rd_ptr_q    <= '0;
      cfg_conj_q  <= 1'b0;
      cfg_shift_q <= '0;
      s1_ctrl_q   <= '0;
      s2_ctrl_q   <= '0;
      sat_flag_q  <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      cfg_conj_q  <= cfg_conj_d;
      cfg_shift_q <= cfg_shift_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s2_ctrl_q   <= s2_ctrl_d;
      sat_flag_q  <= sat_flag_d;
      tlast_err_q <= tlast_err_d;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    s1_data_q <= s1_data_d;
    s2_a_q    <= s2_a_d;
    s2_b_q    <= s2_b_d;
  end

  cmult_pipe #(
    .IN_W  (IN_W),
    .REF_W (REF_W),
    .OUT_W (OUT_W)
  ) u_pipe (
    .clk       (S_AXIS_ACLK),
    .rst_n     (S_AXIS_ARESETN),
    .en        (en),
    .in_ctrl   (s2_ctrl_q),
    .in_a      (s2_a_q),
    .in_b      (s2_b_q),
    .out_valid (m_valid),
    .out_last  (m_last),
    .out_data  (m_data),
    .sat_evt   (sat_evt)
  );

  assign S_AXIS_TREADY = en;
  assign BRAM_EN       = en;
  assign BRAM_ADDR     = rd_ptr_q;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TLAST  = m_last;
  assign M_AXIS_TDATA  = m_data;
  assign SAT_FLAG      = sat_flag_q;
  assign TLAST_ERR     = tlast_err_q;

endmodule

// File: tb/tb_cmult_ref_stream.sv
// Scoreboard bench: driver pushes model results per accepted beat, monitor pops per output handshake.
module tb_cmult_ref_stream;

  localparam int IN_W = 16, REF_W = 16, OUT_W = 16, ADDR_W = 4, FRAME_LEN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [31:0]        s_tdata;
  logic               s_tvalid, s_tlast, s_tready;
  logic [ADDR_W-1:0]  bram_addr;
  logic               bram_en;
  logic [31:0]        bram_q;
  logic [31:0]        m_tdata;
  logic               m_tvalid, m_tlast, m_tready;
  logic               cfg_conj, clr, sat_flag, tlast_err;
  logic [4:0]         cfg_shift;

  cmult_ref_stream #(
    .IN_W(IN_W), .REF_W(REF_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .BRAM_ADDR(bram_addr), .BRAM_EN(bram_en), .BRAM_DATAIN(bram_q),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready),
    .CFG_CONJ(cfg_conj), .CFG_SHIFT(cfg_shift), .CLR_FLAGS(clr),
    .SAT_FLAG(sat_flag), .TLAST_ERR(tlast_err)
  );

  logic [31:0] ref_mem [16];
  always @(posedge clk) if (bram_en) bram_q <= ref_mem[bram_addr];

  typedef struct { int re; int im; bit last; bit sat; int acc; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0, failures = 0, cyc = 0;
  bit rand_ready = 0, lat_chk = 0;
  int m_ptr = 0, m_shift = 0;
  bit m_conj = 0, exp_sat = 0, exp_terr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Reference: exact product, round half up by adding half an LSB, floor-shift, clip.
  function automatic int scale(input longint x, input int sh, output bit sat);
    longint y;
    y = (sh == 0) ? x : ((x + (longint'(1) << (sh - 1))) >>> sh);
    sat = 1'b0;
    if (y > 32767) begin sat = 1'b1; y = 32767; end
    if (y < -32768) begin sat = 1'b1; y = -32768; end
    return int'(y);
  endfunction

  task automatic model_accept(input logic [31:0] d, input bit last);
    exp_t e;
    longint ar, ai, br, bi, re, im;
    bit s1, s2;
    logic [31:0] r;
    chk("bram_addr", bram_addr, m_ptr);
    if (m_ptr == 0) begin m_conj = cfg_conj; m_shift = cfg_shift; end
    if (last != (m_ptr == FRAME_LEN - 1)) exp_terr = 1;
    r  = ref_mem[m_ptr];
    ar = sx(d[15:0]);  ai = sx(d[31:16]);
    br = sx(r[15:0]);  bi = sx(r[31:16]);
    re = m_conj ? ar * br + ai * bi : ar * br - ai * bi;
    im = m_conj ? ai * br - ar * bi : ar * bi + ai * br;
    e.re = scale(re, m_shift, s1);
    e.im = scale(im, m_shift, s2);
    e.sat = s1 | s2;
    e.last = last;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    m_ptr = (m_ptr == FRAME_LEN - 1 || last) ? 0 : m_ptr + 1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    bit done = 0;
    s_tdata = d; s_tvalid = 1; s_tlast = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (s_tready) begin
        done = 1;
        model_accept(d, last);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin @(negedge clk); k++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_flags();
    @(negedge clk);
    chk("sat_flag", sat_flag, exp_sat);
    chk("tlast_err", tlast_err, exp_terr);
    @(posedge clk); #1;
  endtask

  task automatic clear_flags();
    clr = 1; @(posedge clk); #1; clr = 0;
    exp_sat = 0; exp_terr = 0;
    @(negedge clk);
    chk("sat_cleared", sat_flag, 0);
    chk("terr_cleared", tlast_err, 0);
    @(posedge clk); #1;
  endtask

  task automatic fill_ref(input logic [31:0] v);
    for (int i = 0; i < 16; i++) ref_mem[i] = v;
  endtask

  // Output monitor: scoreboard compare, stall stability and unstalled latency.
  logic [31:0] hold_d;
  bit hold_l, hold_v = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, hold_d);
        chk("stall_last", m_tlast, hold_l);
      end
      if (m_tvalid && !hold_v && lat_chk && exp_q.size() > 0)
        chk("latency", cyc - exp_q[0].acc, 4);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_re", $signed(m_tdata[15:0]), mon_e.re);
          chk("out_im", $signed(m_tdata[31:16]), mon_e.im);
          chk("out_last", m_tlast, mon_e.last);
          if (mon_e.sat) exp_sat = 1;
        end
      end
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_l = m_tlast;
    end
  end

  initial begin
    m_tready = 1;
    forever begin
      @(posedge clk); #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; s_tdata = 0; s_tvalid = 0; s_tlast = 0;
    cfg_conj = 0; cfg_shift = 0; clr = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_terr", tlast_err, 0);
    chk("rst_addr", bram_addr, 0);
    @(posedge clk); #1;
    lat_chk = 1;

    // Identity: ref 1.0 at shift 14
    fill_ref({16'd0, 16'd16384});
    cfg_conj = 0; cfg_shift = 14;
    for (int i = 0; i < FRAME_LEN; i++) send_beat({16'd2000, 16'd1000}, i == FRAME_LEN - 1);
    drain(); check_flags();

    // Conjugate against ref j
    fill_ref({16'd16384, 16'd0});
    cfg_conj = 1;
    for (int i = 0; i < FRAME_LEN; i++) send_beat({16'd2000, 16'd1000}, i == FRAME_LEN - 1);
    drain(); check_flags();

    // Saturation at shift 0
    fill_ref(32'h7FFF_7FFF);
    cfg_conj = 0; cfg_shift = 0;
    for (int i = 0; i < FRAME_LEN; i++) send_beat(32'h7FFF_7FFF, i == FRAME_LEN - 1);
    drain(); check_flags(); clear_flags();

    // Random data, config and backpressure
    lat_chk = 0; rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
      for (int i = 0; i < FRAME_LEN; i++) begin
        cfg_conj = 1'($urandom_range(0, 1));
        cfg_shift = 5'($urandom_range(8, 20));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_beat($urandom, i == FRAME_LEN - 1);
      end
    end
    drain();
    rand_ready = 0; @(posedge clk); #1;
    drain(); check_flags(); clear_flags();
    lat_chk = 1;

    // Early TLAST, then a good frame that must restart at ref[0]
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    cfg_shift = 15;
    for (int i = 0; i < 5; i++) send_beat($urandom, i == 4);
    for (int i = 0; i < FRAME_LEN; i++) send_beat($urandom, i == FRAME_LEN - 1);
    drain(); check_flags(); clear_flags();

    // Missing TLAST: pointer wraps, error flagged, left set for the reset test
    for (int i = 0; i < FRAME_LEN; i++) send_beat($urandom, 1'b0);
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0);
    @(negedge clk);
    chk("terr_missing_last", tlast_err, 1);
    chk("ptr_before_reset", bram_addr, 3);
    @(posedge clk); #1;

    // Reset mid-frame discards in-flight beats
    rst_n = 0;
    exp_q.delete();
    m_ptr = 0; m_conj = 0; m_shift = 0; exp_sat = 0; exp_terr = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_terr", tlast_err, 0);
    chk("mid_rst_addr", bram_addr, 0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    cfg_conj = 0; cfg_shift = 14;
    for (int i = 0; i < FRAME_LEN; i++) send_beat($urandom, i == FRAME_LEN - 1);
    drain(); check_flags();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
